// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter: CDB grant between one max-priority EU and N_REQ round-robin RS with a starvation bound
module cdb_rr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int STARVE_MAX = 4,
  parameter int IDX_W      = $clog2(N_REQ+1)
)(
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             max_prio_valid_i,
  output logic             max_prio_ready_o,
  input  logic [N_REQ-1:0] valid_i,
  output logic [N_REQ-1:0] ready_o,
  input  logic             rob_ready_i,
  output logic             rob_valid_o,
  output logic             served_max_prio_o,
  output logic [IDX_W-1:0] served_o
);
  localparam int CNT_W = $clog2(STARVE_MAX+1);
  logic [IDX_W-1:0]   rr_ptr, lp_pick, ofs, next_ptr;
  logic [IDX_W:0]     sum, nsum;
  logic [CNT_W-1:0]   starve_cnt;
  logic [2*N_REQ-1:0] rot;
  logic               any_lp, mp_win, lp_win, starved, active;
  // Rotate the doubled request vector so bit 0 is the RS at rr_ptr; the lowest set bit is the pick.
  always_comb begin
    rot = {valid_i, valid_i} >> rr_ptr;
    ofs = '0;
    for (int i = N_REQ-1; i >= 0; i--)
      if (rot[i]) ofs = IDX_W'(i);
  end
  assign sum      = {1'b0, rr_ptr} + {1'b0, ofs};
  assign lp_pick  = sum >= (IDX_W+1)'(N_REQ) ? IDX_W'(sum - (IDX_W+1)'(N_REQ)) : IDX_W'(sum);
  assign nsum     = {1'b0, lp_pick} + (IDX_W+1)'(1);
  assign next_ptr = nsum == (IDX_W+1)'(N_REQ) ? '0 : IDX_W'(nsum);
  assign any_lp   = |valid_i;
  assign starved  = any_lp && starve_cnt == CNT_W'(STARVE_MAX);
  assign active   = rst_n_i && !flush_i;
  assign mp_win   = active && max_prio_valid_i && !starved;
  assign lp_win   = active && !mp_win && any_lp;
  always_comb begin
    rob_valid_o       = mp_win || lp_win;
    served_max_prio_o = mp_win;
    served_o          = lp_win ? lp_pick + IDX_W'(1) : '0;
    max_prio_ready_o  = mp_win && rob_ready_i;
    ready_o           = lp_win && rob_ready_i ? N_REQ'(1) << lp_pick : '0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || flush_i) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else if (lp_win && rob_ready_i) begin
      rr_ptr     <= next_ptr;
      starve_cnt <= '0;
    end else if (mp_win && rob_ready_i) begin
      starve_cnt <= !any_lp ? '0 : starved ? starve_cnt : starve_cnt + CNT_W'(1);
    end else if (!any_lp) begin
      starve_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// tb_cdb_rr_arbiter: scoreboard bench with a queue-based reference model of the CDB arbiter
module tb_cdb_rr_arbiter;
  logic       clk = 1'b0, rst_n = 1'b0, flush = 1'b0, mp_valid = 1'b0, rob_ready = 1'b0;
  logic [3:0] valid = '0;
  logic       mp_ready, rob_valid, served_mp;
  logic [3:0] ready;
  logic [2:0] served;
  logic [9:0] exp_q[$];
  int         checks = 0, errors = 0, cyc = 0;
  int         m_ptr = 0, m_cnt = 0;

  cdb_rr_arbiter dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .max_prio_valid_i(mp_valid), .max_prio_ready_o(mp_ready),
    .valid_i(valid), .ready_o(ready), .rob_ready_i(rob_ready),
    .rob_valid_o(rob_valid), .served_max_prio_o(served_mp), .served_o(served)
  );

  always #5 clk = ~clk;

  // Reference: scan RS in round-robin order from the model pointer, apply the starvation rule.
  task automatic drive(input logic rn, input logic fl, input logic mp, input logic [3:0] v, input logic rr);
    int pick;
    bit any, mpw, lpw;
    logic [3:0] rd;
    @(posedge clk);
    #1;
    rst_n = rn; flush = fl; mp_valid = mp; valid = v; rob_ready = rr;
    pick = -1;
    any = |v;
    for (int o = 0; o < 4; o++)
      if (pick < 0 && v[(m_ptr + o) % 4]) pick = (m_ptr + o) % 4;
    mpw = rn && !fl && mp && !(any && m_cnt == 4);
    lpw = rn && !fl && !mpw && any;
    rd = (lpw && rr) ? 4'(1 << pick) : 4'b0;
    exp_q.push_back({mpw || lpw, mpw, lpw ? 3'(pick + 1) : 3'd0, mpw && rr, rd});
    if (!rn || fl) begin
      m_ptr = 0; m_cnt = 0;
    end else if (lpw && rr) begin
      m_ptr = (pick + 1) % 4; m_cnt = 0;
    end else if (mpw && rr) begin
      m_cnt = any ? (m_cnt < 4 ? m_cnt + 1 : 4) : 0;
    end else if (!any) begin
      m_cnt = 0;
    end
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    checks++;
    assert ($onehot0({mp_ready, ready}) && (rob_ready || !(mp_ready || |ready))) else begin
      errors++;
      $display("FAIL onehot cyc=%0d got mp_ready=%b ready=%b rob_ready=%b", cyc, mp_ready, ready, rob_ready);
    end
    if (exp_q.size() > 0) begin
      logic [9:0] e;
      e = exp_q.pop_front();
      checks++;
      if ({rob_valid, served_mp, served, mp_ready, ready} !== e) begin
        errors++;
        $display("FAIL cdb_out cyc=%0d got {rv,smp,sel,mprdy,rdy}=%b exp=%b", cyc,
                 {rob_valid, served_mp, served, mp_ready, ready}, e);
      end
    end
  end

  initial begin
    repeat (2) drive(0, 0, 1, 4'b1111, 1);
    drive(1, 0, 0, 4'b0100, 1);
    drive(1, 0, 0, 4'b1111, 1);
    repeat (8) drive(1, 0, 0, 4'b1111, 1);
    repeat (12) drive(1, 0, 1, 4'b0001, 1);
    repeat (3) drive(1, 0, 0, 4'b0011, 0);
    drive(1, 0, 0, 4'b0011, 1);
    drive(1, 0, 0, 4'b0011, 1);
    repeat (3) drive(1, 0, 1, 4'b1000, 1);
    drive(1, 1, 1, 4'b1111, 1);
    drive(1, 0, 0, 4'b1111, 1);
    repeat (2) drive(1, 0, 1, 4'b0110, 1);
    drive(0, 1, 1, 4'b1111, 1);
    drive(1, 0, 0, 4'b1010, 1);
    repeat (6) drive(1, 0, 1, 4'b0000, 1);
    repeat (400) begin
      drive($urandom_range(49) != 0, $urandom_range(19) == 0, $urandom_range(1) == 1,
            4'($urandom_range(15)), $urandom_range(3) != 0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
